// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the pipelined CPU.
// Holds the EXM/WB pipeline register and picks the write-back value. Drives the
// register-file write port and the forwarding bus from that value. Also owns the
// output-port register and reassembles a 32-bit PC from two popped 16-bit words.
//
// Handshake: the stage has no backpressure. i_valid qualifies every other input
// in the cycle it is high. An instruction presented in cycle N is always
// captured at the end of N and retires during N+1. i_flush drops the capture
// taking place at that same edge.
module wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_ex_result,
  input  logic [DATA_W-1:0] i_memory_data,
  input  logic [DATA_W-1:0] i_immediate,
  input  logic [DATA_W-1:0] i_input_port,
  input  logic [1:0]        i_wb_selector,
  input  logic              i_write_back,
  input  logic [REG_AW-1:0] i_write_addr,
  input  logic              i_out_port,
  input  logic              i_pop_pc,
  output logic              o_rf_we,
  output logic [REG_AW-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic [DATA_W-1:0] o_data_wb,
  output logic [DATA_W-1:0] o_out_port,
  output logic              o_pc_load,
  output logic [31:0]       o_pc_value,
  output logic              o_pc_error
);

  typedef enum logic {
    PC_IDLE = 1'b0,
    PC_HALF = 1'b1
  } pc_state_t;

  // EXM/WB pipeline register fields
  logic              valid_r;
  logic [DATA_W-1:0] ex_result_r;
  logic [DATA_W-1:0] memory_data_r;
  logic [DATA_W-1:0] immediate_r;
  logic [DATA_W-1:0] input_port_r;
  logic [1:0]        wb_selector_r;
  logic              write_back_r;
  logic [REG_AW-1:0] write_addr_r;
  logic              out_port_r;
  logic              pop_pc_r;

  // PC reassembly state; pc_state is kept as a named signal so checkers can bind to it
  pc_state_t   pc_state;
  logic [15:0] hi_r;

  logic [DATA_W-1:0] wb_value;

  // Capture the execute/memory results every edge; a flush turns the capture into a bubble
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      valid_r       <= 1'b0;
      ex_result_r   <= '0;
      memory_data_r <= '0;
      immediate_r   <= '0;
      input_port_r  <= '0;
      wb_selector_r <= 2'b00;
      write_back_r  <= 1'b0;
      write_addr_r  <= '0;
      out_port_r    <= 1'b0;
      pop_pc_r      <= 1'b0;
    end else begin
      valid_r       <= i_valid & ~i_flush;
      ex_result_r   <= i_ex_result;
      memory_data_r <= i_memory_data;
      immediate_r   <= i_immediate;
      input_port_r  <= i_input_port;
      wb_selector_r <= i_wb_selector;
      write_back_r  <= i_write_back;
      write_addr_r  <= i_write_addr;
      out_port_r    <= i_out_port;
      pop_pc_r      <= i_pop_pc;
    end
  end

  // Select the write-back value from the registered fields
  always_comb begin
    wb_value = ex_result_r;
    case (wb_selector_r)
      2'b00:   wb_value = ex_result_r;
      2'b01:   wb_value = memory_data_r;
      2'b10:   wb_value = immediate_r;
      2'b11:   wb_value = input_port_r;
      default: wb_value = ex_result_r;
    endcase
  end

  // A popped PC half never reaches the register file
  assign o_rf_we    = valid_r & write_back_r & ~pop_pc_r;
  assign o_rf_waddr = write_addr_r;
  assign o_rf_wdata = wb_value;
  assign o_data_wb  = wb_value;

  // Output-port register is loaded as the OUT instruction retires
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_out_port <= '0;
    end else if (valid_r && out_port_r) begin
      o_out_port <= ex_result_r;
    end
  end

  // PC reassembly FSM: bubbles hold the state; a flush forces IDLE at its edge
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc_state <= PC_IDLE;
      hi_r     <= '0;
    end else begin
      if (valid_r) begin
        case (pc_state)
          PC_IDLE: begin
            if (pop_pc_r) begin
              hi_r     <= memory_data_r[15:0];
              pc_state <= PC_HALF;
            end
          end
          PC_HALF: begin
            // Either the low half completes the PC or the sequence is broken;
            // in both cases the stored high half is no longer needed.
            hi_r     <= '0;
            pc_state <= PC_IDLE;
          end
          default: pc_state <= PC_IDLE;
        endcase
      end
      if (i_flush) begin
        pc_state <= PC_IDLE;
      end
    end
  end

  // Load/error pulses last exactly one WB cycle because the FSM leaves HALF at its end
  assign o_pc_load  = valid_r & pop_pc_r & (pc_state == PC_HALF);
  assign o_pc_error = valid_r & ~pop_pc_r & (pc_state == PC_HALF);
  assign o_pc_value = o_pc_load ? {hi_r, memory_data_r[15:0]} : 32'h0;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the pipelined CPU, directly downstream of the execute/memory stage. Registers that stage's results in the EXM/WB pipeline register, selects the write-back value, and drives the register-file write port and the forwarding bus back into execute/memory. Also owns the output-port register and a two-word PC-reassembly FSM for RET/RTI pops, which issues a single 32-bit PC load to fetch.

## Interface
- DATA_W, 16, data/result width
- REG_AW, 3, register-file address width

- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_valid  in  1  execute/memory stage holds a real instruction this cycle
- i_flush  in  1  discard the instruction being captured; return PC FSM to IDLE
- i_ex_result  in  DATA_W  ALU/mov result
- i_memory_data  in  DATA_W  data-memory read word
- i_immediate  in  DATA_W  immediate field
- i_input_port  in  DATA_W  external input port, sampled at capture
- i_wb_selector  in  2  00 ex_result, 01 memory_data, 10 immediate, 11 input_port
- i_write_back  in  1  instruction writes the register file
- i_write_addr  in  REG_AW  destination register
- i_out_port  in  1  OUT instruction
- i_pop_pc  in  1  memory word is a popped PC half
- o_rf_we  out  1  register-file write enable
- o_rf_waddr  out  REG_AW  register-file write address
- o_rf_wdata  out  DATA_W  register-file write data
- o_data_wb  out  DATA_W  forwarding data (equals o_rf_wdata)
- o_out_port  out  DATA_W  output-port register
- o_pc_load  out  1  one-cycle pulse: load o_pc_value into PC
- o_pc_value  out  32  reassembled PC
- o_pc_error  out  1  one-cycle pulse: PC pop sequence broken

## Operation
- Stage register: on each edge captures all data/control inputs; valid_r <= i_valid & ~i_flush. Flush wins over valid. Input port sampled into the register (captured value, not live pin).
- Write-back mux over registered fields per wb_selector_r; o_rf_wdata = o_data_wb = mux output (combinational from stage register).
- o_rf_we = valid_r & write_back_r & ~pop_pc_r; o_rf_waddr = write_addr_r.
- Output port: at edge, if valid_r & out_port_r then o_out_port <= ex_result_r; otherwise holds.
- PC FSM, states IDLE, HALF; registers hi_r[15:0].
  - IDLE, valid_r & pop_pc_r: hi_r <= memory_data_r; -> HALF.
  - HALF, valid_r & pop_pc_r: o_pc_load = 1, o_pc_value = {hi_r, memory_data_r}; -> IDLE.
  - HALF, valid_r & ~pop_pc_r: o_pc_error = 1; hi_r discarded; -> IDLE; that instruction still writes back normally.
  - Bubbles (valid_r = 0) never change FSM state.
  - i_flush asserted: -> IDLE at that edge (overrides any transition), no o_pc_load/o_pc_error from the flushed capture.
- o_pc_value = 0 whenever o_pc_load = 0.

## Timing
- Latency: inputs presented in cycle N appear on o_rf_*/o_data_wb in cycle N+1; register file writes at end of N+1.
- o_pc_load/o_pc_error combinational in the WB cycle of the triggering word, exactly one cycle wide.
- o_out_port updates at the edge ending the OUT instruction's WB cycle (visible N+2).
- Reset (i_reset = 0 at edge): valid_r = 0, all stage fields 0, FSM IDLE, hi_r = 0, o_out_port = 0. Hence after reset o_rf_we = 0, o_rf_waddr = 0, o_rf_wdata = o_data_wb = 0, o_pc_load = 0, o_pc_value = 0, o_pc_error = 0. Reset mid-pop discards the high half.
- Reset has priority over flush and valid.

## Test plan
- Reset: hold i_reset = 0 two cycles with i_valid = 1, random data -> all outputs 0, no rf write.
- Mux/latency: i_valid = 1, wb_selector 00/01/10/11 with ex 0x1111, mem 0x2222, imm 0x3333, port 0x4444, write_back = 1, addr 5 -> next cycle o_rf_we = 1, addr 5, wdata 0x1111/0x2222/0x3333/0x4444 respectively; write_back = 0 -> o_rf_we = 0.
- PC pop: pop_pc words 0x0001 then 0x8000 (bubble between) -> o_pc_load one cycle, o_pc_value = 0x00018000, o_rf_we = 0 on both.
- Broken pop: pop_pc 0x00AA then ADD (write_back, addr 2) -> o_pc_error pulse, no o_pc_load, R2 written; next pop pair 0x0000/0x0010 -> o_pc_value = 0x00000010.
- Flush: i_flush with i_valid = 1, write_back = 1 -> o_rf_we = 0 next cycle; flush during HALF -> following single pop word gives no load.
- Output port: OUT with ex_result 0xBEEF -> o_out_port = 0xBEEF two cycles after presentation, held through later non-OUT instructions.
